// File: rtl/nexys_starship_pkg.sv
// Shared BCD constants and helpers for the starship game clock.
// Latency: none (package only).
// Backpressure: none (package only).
package nexys_starship_pkg;

    localparam int              BCD_W        = 4;
    localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;
    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

    // A BCD digit is usable only if it does not exceed the digit's own ceiling
    function automatic logic bcd_valid(input logic [BCD_W-1:0] digit,
                                       input logic [BCD_W-1:0] lim);
        return digit <= lim;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the game clock with load, increment and decrement.
// Latency: value updates on the clock edge after an enable; status flags are combinational from the register.
// Backpressure: none; the enables are single-cycle commands from the parent.
module bcd_digit_counter
    import nexys_starship_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = DIGIT_MAX
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [BCD_W-1:0] i_load_val,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [BCD_W-1:0] o_val,
    output logic             o_at_max,
    output logic             o_at_zero
);

    logic [BCD_W-1:0] r_val;

    // Digit register: clear beats load beats count; inc rolls MAX->0, dec rolls 0->MAX
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_val <= '0;
        end else if (i_clr) begin
            r_val <= '0;
        end else if (i_load) begin
            r_val <= i_load_val;
        end else if (i_inc) begin
            r_val <= (r_val == MAX) ? '0 : r_val + BCD_W'(1);
        end else if (i_dec) begin
            r_val <= (r_val == '0) ? MAX : r_val - BCD_W'(1);
        end
    end

    // The next digit up carries when this one is at MAX, borrows when it is at zero
    assign o_val     = r_val;
    assign o_at_max  = (r_val == MAX);
    assign o_at_zero = (r_val == '0);

endmodule

// File: rtl/nexys_starship_game_timer.sv
// BCD game clock M..M:SS with prescaler, up/down count, pause, load, saturate/wrap and expiry flags.
// Latency: tick is combinational on prescaler terminal; time shows next cycle; level/pulse flags registered one cycle later.
// Backpressure: none; run=0 freezes the prescaler, clear/load pre-empt counting for that cycle.
module nexys_starship_game_timer
    import nexys_starship_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 1,
    parameter int MIN_DIGITS = 1,
    parameter int SATURATE   = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_run,
    input  logic                        i_clear,
    input  logic                        i_load,
    input  logic                        i_mode_down,
    input  logic [BCD_W*MIN_DIGITS-1:0] i_load_min,
    input  logic [7:0]                  i_load_sec,
    output logic [BCD_W*MIN_DIGITS-1:0] o_min_bcd,
    output logic [BCD_W-1:0]            o_sec_tens,
    output logic [BCD_W-1:0]            o_sec_ones,
    output logic                        o_tick,
    output logic                        o_expired,
    output logic                        o_expire_pulse,
    output logic                        o_at_limit,
    output logic                        o_wrap_pulse,
    output logic                        o_load_err
);

    localparam int              TERM   = CLK_HZ / TICK_HZ - 1;
    localparam int              PRE_W  = (TERM < 1) ? 1 : $clog2(TERM + 1);
    localparam logic [PRE_W-1:0] TERM_C = PRE_W'(TERM);
    // Digit 0 = seconds ones, 1 = seconds tens, 2.. = minutes (least significant first)
    localparam int              N_DIG  = MIN_DIGITS + 2;

    function automatic logic [BCD_W-1:0] f_dmax(input int idx);
        return (idx == 1) ? SEC_TENS_MAX : DIGIT_MAX;
    endfunction

    logic [PRE_W-1:0] r_presc;
    logic             r_expired, r_expire_pulse, r_at_limit, r_wrap_pulse, r_load_err;

    logic [BCD_W-1:0] w_val    [N_DIG];
    logic [BCD_W-1:0] w_ld_val [N_DIG];
    logic             w_at_max [N_DIG];
    logic             w_at_zero[N_DIG];
    logic             w_inc    [N_DIG];
    logic             w_dec    [N_DIG];
    logic             w_load_ok, w_ld, w_zero, w_max, w_one;
    logic             w_tick, w_up_en, w_dn_en, w_wrap;

    assign w_ld_val[0] = i_load_sec[3:0];
    assign w_ld_val[1] = i_load_sec[7:4];
    assign o_sec_ones  = w_val[0];
    assign o_sec_tens  = w_val[1];

    genvar gi;
    generate
        for (gi = 0; gi < MIN_DIGITS; gi++) begin : g_min_map
            assign w_ld_val[gi+2]             = i_load_min[BCD_W*gi +: BCD_W];
            assign o_min_bcd[BCD_W*gi +: BCD_W] = w_val[gi+2];
        end
        for (gi = 0; gi < N_DIG; gi++) begin : g_dig
            bcd_digit_counter #(.MAX(f_dmax(gi))) u_dig (
                .i_clk      (i_clk),
                .i_rst_n    (i_rst_n),
                .i_clr      (i_clear),
                .i_load     (w_ld),
                .i_load_val (w_ld_val[gi]),
                .i_inc      (w_inc[gi]),
                .i_dec      (w_dec[gi]),
                .o_val      (w_val[gi]),
                .o_at_max   (w_at_max[gi]),
                .o_at_zero  (w_at_zero[gi])
            );
        end
    endgenerate

    // Load validation, time status, tick qualification and the carry/borrow ripple
    always_comb begin
        logic up_c, dn_c;
        w_load_ok = 1'b1;
        w_zero    = 1'b1;
        w_max     = 1'b1;
        w_one     = (w_val[0] == BCD_W'(1));
        for (int i = 0; i < N_DIG; i++) begin
            if (!bcd_valid(w_ld_val[i], f_dmax(i))) w_load_ok = 1'b0;
            if (!w_at_zero[i])                      w_zero    = 1'b0;
            if (!w_at_max[i])                       w_max     = 1'b0;
            if (i != 0 && !w_at_zero[i])            w_one     = 1'b0;
        end
        w_ld    = i_load && !i_clear && w_load_ok;
        w_tick  = i_run && !i_clear && !i_load && (r_presc == TERM_C);
        // Saturating mode simply drops the tick at max; down mode drops it at zero
        w_up_en = w_tick && !i_mode_down && !((SATURATE != 0) && w_max);
        w_dn_en = w_tick && i_mode_down && !w_zero;
        up_c    = w_up_en;
        dn_c    = w_dn_en;
        for (int i = 0; i < N_DIG; i++) begin
            w_inc[i] = up_c;
            w_dec[i] = dn_c;
            up_c     = up_c && w_at_max[i];
            dn_c     = dn_c && w_at_zero[i];
        end
        // A carry out of the top digit means every digit rolled over to zero
        w_wrap = up_c;
    end

    // Prescaler: restarts on clear/accepted load, holds on pause or rejected load
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc <= '0;
        end else if (i_clear || w_ld || w_tick) begin
            r_presc <= '0;
        end else if (i_run && !i_load) begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    // Status levels follow the current time one cycle late; pulses mark this cycle's events
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_expired      <= 1'b0;
            r_at_limit     <= 1'b0;
            r_expire_pulse <= 1'b0;
            r_wrap_pulse   <= 1'b0;
            r_load_err     <= 1'b0;
        end else begin
            r_expired      <= i_mode_down && w_zero;
            r_at_limit     <= !i_mode_down && w_max;
            r_expire_pulse <= w_dn_en && w_one;
            r_wrap_pulse   <= w_wrap;
            r_load_err     <= i_load && !i_clear && !w_load_ok;
        end
    end

    assign o_tick         = w_tick;
    assign o_expired      = r_expired;
    assign o_at_limit     = r_at_limit;
    assign o_expire_pulse = r_expire_pulse;
    assign o_wrap_pulse   = r_wrap_pulse;
    assign o_load_err     = r_load_err;

endmodule
